// File: rtl/alu_serial32.sv
// Bit-serial ALU: one 1-bit slice evaluated per clock, LSB first, with a registered carry.
// Word-level start/busy/done handshake; result and flags are written at the final bit.
module alu_serial32 #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [2:0] OpAnd = 3'b000;
    localparam logic [2:0] OpOr  = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpXor = 3'b011;
    localparam logic [2:0] OpSub = 3'b110;
    localparam logic [2:0] OpSlt = 3'b111;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [2:0]       op_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;

    logic             is_sub, arith;
    logic             ai, bi, sum_bit, carry_nxt, slice_bit, ovf_bit;
    logic [WIDTH-1:0] shifted_res, final_res;

    // Slice: operands are shifted right so bit 0 always holds the current bit.
    always_comb begin
        is_sub    = (op_q == OpSub) || (op_q == OpSlt);
        arith     = (op_q == OpAdd) || is_sub;
        ai        = a_q[0];
        bi        = b_q[0] ^ is_sub;
        sum_bit   = ai ^ bi ^ carry_q;
        carry_nxt = (ai & bi) | (ai & carry_q) | (bi & carry_q);
        ovf_bit   = carry_q ^ carry_nxt;
        case (op_q)
            OpAnd:               slice_bit = ai & bi;
            OpOr:                slice_bit = ai | bi;
            OpXor:               slice_bit = ai ^ bi;
            OpAdd, OpSub, OpSlt: slice_bit = sum_bit;
            default:             slice_bit = 1'b0;
        endcase
        shifted_res = {slice_bit, res_q[WIDTH-1:1]};
        if (op_q == OpSlt) begin
            final_res = {{(WIDTH - 1){1'b0}}, sum_bit ^ ovf_bit};
        end else begin
            final_res = shifted_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            op_q      <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= alu_op;
                        res_q   <= '0;
                        carry_q <= (alu_op == OpSub) || (alu_op == OpSlt);
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= shifted_res;
                    carry_q <= carry_nxt;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        result    <= final_res;
                        carry_out <= arith && (op_q != OpSlt) && carry_nxt;
                        overflow  <= arith && (op_q != OpSlt) && ovf_bit;
                        zero      <= (final_res == '0);
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial32.sv
// Directed self-checking bench for alu_serial32: latency, arithmetic/logic results,
// flags, ignored starts and asynchronous reset mid-operation.
module tb_alu_serial32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  alu_op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;
    logic        carry_out, overflow, zero;

    int pass_cnt = 0;
    int total    = 0;

    alu_serial32 #(.WIDTH(32), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .alu_op    (alu_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation; operands are scrambled right after the start edge.
    task automatic do_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output bit busy_ok, output bit done_one);
        @(negedge clk);
        alu_op = op; a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = ~x; b = ~y; alu_op = 3'b001;
        busy_ok = busy && !done;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = k;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        done_one = !done && !busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; alu_op = 3'b000; a = '0; b = '0;
        #12;
        total++;
        if ({busy, done, result, carry_out, overflow, zero} !== 37'd0) begin
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h co=%b ov=%b z=%b, want all 0",
                     busy, done, result, carry_out, overflow, zero);
        end else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int lat; bit bok, d1;
        do_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0001, lat, bok, d1);
        total++;
        if (lat !== 32) $display("FAIL add_latency: got %0d, want 32", lat); else pass_cnt++;
        total++;
        if (!bok) $display("FAIL add_busy: busy not held through run, got 0, want 1"); else pass_cnt++;
        total++;
        if (!d1) $display("FAIL add_done_pulse: done/busy not low after one cycle, got 0, want 1");
        else pass_cnt++;
        total++;
        if ({result, carry_out, overflow, zero} !== {32'h0, 1'b1, 1'b0, 1'b1})
            $display("FAIL add_wrap: got %h co=%b ov=%b z=%b, want 00000000 co=1 ov=0 z=1",
                     result, carry_out, overflow, zero);
        else pass_cnt++;

        do_op(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, lat, bok, d1);
        total++;
        if ({result, carry_out, overflow, zero} !== {32'h8000_0000, 1'b0, 1'b1, 1'b0})
            $display("FAIL add_ovf: got %h co=%b ov=%b z=%b, want 80000000 co=0 ov=1 z=0",
                     result, carry_out, overflow, zero);
        else pass_cnt++;
    endtask

    task automatic test_sub_slt();
        int lat; bit bok, d1;
        do_op(3'b110, 32'd5, 32'd7, lat, bok, d1);
        total++;
        if ({result, carry_out, overflow, zero} !== {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0})
            $display("FAIL sub_5_7: got %h co=%b ov=%b z=%b, want fffffffe co=0 ov=0 z=0",
                     result, carry_out, overflow, zero);
        else pass_cnt++;
        do_op(3'b110, 32'd9, 32'd4, lat, bok, d1);
        total++;
        if ({result, carry_out, overflow} !== {32'd5, 1'b1, 1'b0})
            $display("FAIL sub_9_4: got %h co=%b ov=%b, want 00000005 co=1 ov=0",
                     result, carry_out, overflow);
        else pass_cnt++;
        do_op(3'b111, 32'h8000_0000, 32'h7FFF_FFFF, lat, bok, d1);
        total++;
        if ({result, carry_out, overflow, zero} !== {32'h1, 1'b0, 1'b0, 1'b0})
            $display("FAIL slt_neg_pos: got %h co=%b ov=%b z=%b, want 00000001 co=0 ov=0 z=0",
                     result, carry_out, overflow, zero);
        else pass_cnt++;
        do_op(3'b111, 32'h0000_0001, 32'hFFFF_FFFF, lat, bok, d1);
        total++;
        if ({result, carry_out, overflow, zero} !== {32'h0, 1'b0, 1'b0, 1'b1})
            $display("FAIL slt_pos_neg: got %h co=%b ov=%b z=%b, want 00000000 co=0 ov=0 z=1",
                     result, carry_out, overflow, zero);
        else pass_cnt++;
    endtask

    task automatic test_logic();
        int lat; bit bok, d1;
        logic [2:0]  ops  [4] = '{3'b000, 3'b001, 3'b011, 3'b100};
        logic [31:0] exps [4] = '{32'h00F0_0000, 32'hFFF0_FFFF, 32'hFF00_FFFF, 32'h0};
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], 32'hF0F0_A5A5, 32'h0FF0_5A5A, lat, bok, d1);
            total++;
            if ({result, carry_out, overflow, zero} !== {exps[i], 1'b0, 1'b0, exps[i] == 32'h0})
                $display("FAIL logic_op%b: got %h co=%b ov=%b z=%b, want %h co=0 ov=0 z=%b",
                         ops[i], result, carry_out, overflow, zero, exps[i], exps[i] == 32'h0);
            else pass_cnt++;
            total++;
            if (lat !== 32) $display("FAIL logic_lat_op%b: got %0d, want 32", ops[i], lat);
            else pass_cnt++;
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        bit seen = 0;
        @(negedge clk);
        alu_op = 3'b010; a = 32'h1234_5678; b = 32'h1111_1111; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dones++;
        end
        start = 1'b1; a = 32'd1; b = 32'd1; alu_op = 3'b011;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                dones++;
                seen = 1;
                start = 1'b1; a = 32'd5; b = 32'd5; alu_op = 3'b010;
                break;
            end
        end
        total++;
        if (!seen) $display("FAIL ignore_done_seen: got no done, want one"); else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dones++;
        end
        total++;
        if (dones !== 1) $display("FAIL ignore_done_count: got %0d, want 1", dones);
        else pass_cnt++;
        total++;
        if (result !== 32'h2345_6789 || busy !== 1'b0)
            $display("FAIL ignore_result: got %h busy=%b, want 23456789 busy=0", result, busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat; bit bok, d1;
        int dones = 0;
        @(negedge clk);
        alu_op = 3'b010; a = 32'hFFFF_0000; b = 32'h0000_FFFF; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, result, carry_out, overflow, zero} !== 37'd0)
            $display("FAIL reset_mid_outputs: got busy=%b done=%b result=%h co=%b ov=%b z=%b, want all 0",
                     busy, done, result, carry_out, overflow, zero);
        else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) dones++;
        end
        total++;
        if (dones !== 0) $display("FAIL reset_mid_no_done: got %0d active cycles, want 0", dones);
        else pass_cnt++;
        do_op(3'b010, 32'd3, 32'd4, lat, bok, d1);
        total++;
        if (result !== 32'd7 || lat !== 32 || zero !== 1'b0)
            $display("FAIL reset_mid_recover: got %h lat=%0d z=%b, want 00000007 lat=32 z=0",
                     result, lat, zero);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_slt();
        test_logic();
        test_ignore_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
